// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: wide unsigned adder (N*WORDS bits) built by stepping one
// N-bit adder slice over WORDS cycles, least-significant slice first, with
// the carry registered between slices.
//
// Optional feature: define ADDSEQ_OVF_EN to add the ovf_out port, which
// reports two's-complement overflow of the full W-bit add.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. start_ready is high only in IDLE, and a request is taken on the
// first edge where start_valid is high there. res_valid is high only in DONE,
// and sum_out/cout_out hold steady until the edge where res_ready is high.
// A valid source never needs to watch ready before asserting valid.
module adder_seq_ctrl #(
   parameter int N     = 16,
   parameter int WORDS = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_valid,
   output logic                 start_ready,
   input  logic [N*WORDS-1:0]   a_in,
   input  logic [N*WORDS-1:0]   b_in,
   input  logic                 cin_in,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [N*WORDS-1:0]   sum_out,
   output logic                 cout_out,
`ifdef ADDSEQ_OVF_EN
   output logic                 ovf_out,
`endif
   output logic                 busy,
   output logic [1:0]           state_dbg
);

   localparam int W    = N * WORDS;
   localparam int IDXW = $clog2(WORDS);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   logic [IDXW-1:0] idx;
   logic            carry;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic [N-1:0]    a_slice;
   logic [N-1:0]    b_slice;
   logic [N:0]      slice_res;

   // The current state is exported as-is so checkers can follow the FSM.
   assign state_dbg = state;

   // One adder slice: selected operand words plus the registered carry,
   // kept N+1 bits wide so the carry-out is never truncated away.
   always_comb begin
      a_slice   = a_q[idx*N +: N];
      b_slice   = b_q[idx*N +: N];
      slice_res = {1'b0, a_slice} + {1'b0, b_slice} + {{N{1'b0}}, carry};
   end

   // Control FSM with registered datapath and handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         idx         <= '0;
         carry       <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         sum_out     <= '0;
         cout_out    <= 1'b0;
`ifdef ADDSEQ_OVF_EN
         ovf_out     <= 1'b0;
`endif
         start_ready <= 1'b1;
         res_valid   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_valid) begin
                  a_q         <= a_in;
                  b_q         <= b_in;
                  carry       <= cin_in;
                  idx         <= '0;
                  sum_out     <= '0;
                  cout_out    <= 1'b0;
`ifdef ADDSEQ_OVF_EN
                  ovf_out     <= 1'b0;
`endif
                  start_ready <= 1'b0;
                  busy        <= 1'b1;
                  state       <= RUN;
               end
            end
            RUN: begin
               sum_out[idx*N +: N] <= slice_res[N-1:0];
               carry               <= slice_res[N];
               if (idx == LAST_IDX) begin
                  idx       <= '0;
                  cout_out  <= slice_res[N];
`ifdef ADDSEQ_OVF_EN
                  // Signed overflow: like-signed operands, result sign differs.
                  ovf_out   <= (a_q[W-1] == b_q[W-1]) &&
                               (slice_res[N-1] != a_q[W-1]);
`endif
                  res_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               // Leaving DONE lands in IDLE; a new start needs another edge.
               if (res_ready) begin
                  res_valid   <= 1'b0;
                  busy        <= 1'b0;
                  start_ready <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Testbench for adder_seq_ctrl (N=16, WORDS=4). Expected results come from
// a full-width reference add pushed on each accepted request and popped on
// each result handshake. Honors ADDSEQ_OVF_EN when defined.
module tb_adder_seq_ctrl;

   localparam int N     = 16;
   localparam int WORDS = 4;
   localparam int W     = N * WORDS;
   localparam int EW    = W + 2;   // {ovf, cout, sum}

   logic          clk;
   logic          rst_n;
   logic          start_valid;
   logic          start_ready;
   logic [W-1:0]  a_in;
   logic [W-1:0]  b_in;
   logic          cin_in;
   logic          res_valid;
   logic          res_ready;
   logic [W-1:0]  sum_out;
   logic          cout_out;
   logic          ovf_obs;
   logic          busy;
   logic [1:0]    state_dbg;

   int            checks;
   int            failures;
   logic [EW-1:0] exp_q[$];
   int            edge_cnt;
   int            acc_edge;
   int            prev_acc_edge;
   logic          rv_prev;
   logic          b2b;
   int            n_accepts;

   adder_seq_ctrl #(.N(N), .WORDS(WORDS)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .a_in        (a_in),
      .b_in        (b_in),
      .cin_in      (cin_in),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .sum_out     (sum_out),
      .cout_out    (cout_out),
`ifdef ADDSEQ_OVF_EN
      .ovf_out     (ovf_obs),
`endif
      .busy        (busy),
      .state_dbg   (state_dbg)
   );

`ifndef ADDSEQ_OVF_EN
   assign ovf_obs = 1'b0;
`endif

   // Clock and edge counter
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt = edge_cnt + 1;

   task automatic check(input string tag, input logic [EW-1:0] got,
                        input logic [EW-1:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         failures = failures + 1;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model: full-width add, carry out of bit W-1, signed overflow.
   function automatic logic [EW-1:0] model(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic c);
      logic [W:0] full;
      logic       ovf;
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
`ifdef ADDSEQ_OVF_EN
      ovf = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
`else
      ovf = 1'b0;
`endif
      return {ovf, full};
   endfunction

   // Monitor: push on start handshake, pop on result handshake, timing checks.
   always @(negedge clk) begin
      if (rst_n) begin
         if (start_valid && start_ready) begin
            exp_q.push_back(model(a_in, b_in, cin_in));
            check("accept_not_busy", EW'(busy), EW'(0));
            acc_edge = edge_cnt + 1;
            n_accepts = n_accepts + 1;
            if (b2b && prev_acc_edge >= 0)
               check("b2b_spacing", EW'(acc_edge - prev_acc_edge), EW'(WORDS + 2));
            prev_acc_edge = b2b ? acc_edge : -1;
         end
         if (res_valid && !rv_prev)
            check("latency", EW'(edge_cnt - acc_edge), EW'(WORDS));
         if (res_valid && res_ready) begin
            if (exp_q.size() == 0)
               check("sb_empty", EW'(1), EW'(0));
            else
               check("result", {ovf_obs, cout_out, sum_out}, exp_q.pop_front());
         end
         rv_prev = res_valid;
      end else begin
         rv_prev = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request and hold it until the accept edge has passed.
   task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic c);
      int k;
      a_in = a; b_in = b; cin_in = c; start_valid = 1'b1;
      for (k = 0; k < 50; k++) begin
         @(negedge clk);
         if (start_ready) break;
      end
      if (k == 50) check("start_timeout", EW'(1), EW'(0));
      tick();
      start_valid = 1'b0;
   endtask

   // Wait until every pushed result has been popped and the block is idle.
   task automatic wait_idle();
      int k;
      for (k = 0; k < 100; k++) begin
         if (exp_q.size() == 0 && start_ready) break;
         tick();
      end
      if (k == 100) check("idle_timeout", EW'(1), EW'(0));
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c);
      drive_start(a, b, c);
      wait_idle();
   endtask

   initial begin
      logic [EW-1:0] held;
      int k;
      checks = 0; failures = 0; edge_cnt = 0; acc_edge = 0;
      prev_acc_edge = -1; rv_prev = 1'b0; b2b = 1'b0; n_accepts = 0;
      rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b1;
      a_in = '0; b_in = '0; cin_in = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // Reset state
      check("rst_sum", EW'(sum_out), EW'(0));
      check("rst_flags", EW'({ovf_obs, cout_out, res_valid, busy, start_ready}),
            EW'(5'b00001));

      // Directed operations
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
      run_op(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b1);
      run_op(64'h0, 64'h0, 1'b1);
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      for (int i = 0; i < 4; i++)
         run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));

      // Backpressure: result must hold while res_ready is low
      res_ready = 1'b0;
      drive_start(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
      for (k = 0; k < 20 && !res_valid; k++) tick();
      check("bp_valid_seen", EW'(res_valid), EW'(1));
      held = model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
      for (int i = 0; i < 10; i++) begin
         a_in = {$urandom, $urandom}; b_in = {$urandom, $urandom};
         start_valid = ~start_valid;
         tick();
         check("bp_hold", {ovf_obs, cout_out, sum_out}, held);
         check("bp_ctrl", EW'({res_valid, start_ready, busy}), EW'(3'b101));
      end
      start_valid = 1'b0;
      res_ready = 1'b1;
      tick();
      check("bp_release", EW'({res_valid, start_ready, busy}), EW'(3'b010));
      wait_idle();

      // Reset in the middle of RUN
      drive_start(64'hAAAA_5555_AAAA_5555, 64'h1111_2222_3333_4444, 1'b0);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("midrst_sum", EW'(sum_out), EW'(0));
      check("midrst_flags", EW'({ovf_obs, cout_out, res_valid, busy}), EW'(0));
      exp_q.delete();
      tick();
      rst_n = 1'b1;
      tick();
      check("midrst_ready", EW'(start_ready), EW'(1));
      run_op(64'h5, 64'h7, 1'b0);
      check("small_sum", EW'({cout_out, sum_out}), EW'(64'hC));

      // Back-to-back requests with start_valid held high
      b2b = 1'b1; prev_acc_edge = -1; n_accepts = 0;
      a_in = {$urandom, $urandom}; b_in = {$urandom, $urandom}; cin_in = 1'b1;
      start_valid = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (busy) begin
            a_in = {$urandom, $urandom}; b_in = {$urandom, $urandom};
         end
      end
      start_valid = 1'b0;
      b2b = 1'b0;
      wait_idle();
      check("b2b_count", EW'(n_accepts >= 4), EW'(1));

`ifdef ADDSEQ_OVF_EN
      run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
      check("ovf_pos", EW'({ovf_obs, cout_out}), EW'(2'b10));
      run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
      check("ovf_neg", {ovf_obs, cout_out, sum_out}, {2'b11, 64'h0});
`endif

      repeat (2) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
